game_over_ctrl: RTL

GAME_OVER_CTRL -- requirements
Module: game_over_ctrl

---
 rtl/game_over_ctrl_pkg.sv | 21 ++
 rtl/game_over_ctrl_key_edge_detect.sv | 29 ++
 rtl/game_over_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/game_over_ctrl_pkg.sv
// Shared game definitions: state encoding and default game tuning values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_over_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_ENDED = 2'd3
  } game_state_t;

  localparam int DEF_START_LIVES    = 3;
  localparam int DEF_DEATH_FRAMES   = 60;
  localparam int DEF_MIN_END_FRAMES = 120;
  localparam int DEF_MAX_CREDITS    = 9;

  // Wide enough for any sensible frame count in DYING or ENDED.
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/game_over_ctrl_key_edge_detect.sv
// Registered rising-edge detector for a synchronous key level.
// Latency: pulse appears one cycle after the key is first sampled high.
// Backpressure: none; a held key yields exactly one pulse.
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic pulse
);

  // armed stays low for the first cycle after reset so a key already held
  // during reset is taken as the previous level, not as a fresh press.
  logic armed;
  logic key_q;

  // Track previous key level and emit a one-cycle pulse on a 0->1 change.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed <= 1'b0;
      key_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      armed <= 1'b1;
      key_q <= key;
      pulse <= armed & key & ~key_q;
    end
  end

endmodule

// File: rtl/game_over_ctrl.sv
// Game flow controller: start/credit handling, lives, death freeze, end screen, high score.
// Latency: every output is registered; a key press reaches the outputs two cycles after it is sampled.
// Backpressure: none; pulses arriving in states that do not use them are dropped.
module game_over_ctrl
  import game_over_ctrl_pkg::*;
#(
  parameter int START_LIVES    = DEF_START_LIVES,
  parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
  parameter int MIN_END_FRAMES = DEF_MIN_END_FRAMES,
  parameter int MAX_CREDITS    = DEF_MAX_CREDITS
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        playerHit,
  input  logic        invadersLanded,
  input  logic [15:0] score,
  input  logic        keyStart,
  input  logic        keyCredit,
  output logic        gameEnded,
  output logic        newHighScore,
  output logic        gamePlaying,
  output logic        restartPulse,
  output logic [1:0]  lives,
  output logic [3:0]  credits,
  output logic [15:0] highScore
);

  localparam logic [FRAME_CNT_W-1:0] DEATH_LAST = FRAME_CNT_W'(DEATH_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] END_SAT    = FRAME_CNT_W'(MIN_END_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE    = FRAME_CNT_W'(1);
  localparam logic [3:0]             CREDIT_SAT = 4'(MAX_CREDITS);
  localparam logic [1:0]             LIVES_INIT = 2'(START_LIVES);

  logic start_edge;
  logic credit_edge;

  game_state_t state;
  game_state_t state_nxt;
  logic        start_ok;
  logic        death_done;
  logic        landed_live;

  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt_nxt;
  logic [1:0]             lives_nxt;
  logic [3:0]             credits_nxt;
  logic [15:0]            high_nxt;
  logic                   new_hs_nxt;
  logic                   enter_ended;
  logic                   enter_play;

  key_edge_detect u_start_edge (
    .clk    (clk),
    .resetN (resetN),
    .key    (keyStart),
    .pulse  (start_edge)
  );

  key_edge_detect u_credit_edge (
    .clk    (clk),
    .resetN (resetN),
    .key    (keyCredit),
    .pulse  (credit_edge)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; invadersLanded outranks playerHit, and a start needs a credit.
  always_comb begin
    start_ok    = start_edge && (credits != 4'd0) &&
                  ((state == ST_IDLE) || ((state == ST_ENDED) && (frame_cnt == END_SAT)));
    death_done  = startOfFrame && (frame_cnt == DEATH_LAST);
    landed_live = invadersLanded && ((state == ST_PLAY) || (state == ST_DYING));
    state_nxt   = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_PLAY;
      ST_PLAY:  if (invadersLanded) state_nxt = ST_ENDED;
                else if (playerHit) state_nxt = ST_DYING;
      ST_DYING: if (invadersLanded) state_nxt = ST_ENDED;
                else if (death_done) state_nxt = (lives == 2'd0) ? ST_ENDED : ST_PLAY;
      ST_ENDED: if (start_ok) state_nxt = ST_PLAY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of counters, lives, credits and the high-score bookkeeping.
  always_comb begin
    enter_ended = (state_nxt == ST_ENDED) && (state != ST_ENDED);
    enter_play  = (state_nxt == ST_PLAY) && (state != ST_PLAY);

    // Spend first, then add, so a press at the ceiling while starting still nets zero.
    credits_nxt = credits;
    if (start_ok) credits_nxt = credits - 4'd1;
    if (credit_edge && (credits_nxt < CREDIT_SAT)) credits_nxt = credits_nxt + 4'd1;

    lives_nxt = lives;
    if (start_ok) lives_nxt = LIVES_INIT;
    else if (landed_live) lives_nxt = 2'd0;
    else if ((state == ST_PLAY) && playerHit && (lives != 2'd0)) lives_nxt = lives - 2'd1;

    frame_cnt_nxt = frame_cnt;
    if (state_nxt != state) frame_cnt_nxt = '0;
    else if ((state == ST_DYING) && startOfFrame) frame_cnt_nxt = frame_cnt + CNT_ONE;
    else if ((state == ST_ENDED) && startOfFrame && (frame_cnt < END_SAT))
      frame_cnt_nxt = frame_cnt + CNT_ONE;

    high_nxt   = highScore;
    new_hs_nxt = newHighScore;
    if (enter_ended) begin
      new_hs_nxt = (score > highScore);
      if (score > highScore) high_nxt = score;
    end else if (enter_play) begin
      new_hs_nxt = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt    <= '0;
      lives        <= 2'd0;
      credits      <= 4'd0;
      highScore    <= 16'd0;
      newHighScore <= 1'b0;
      gameEnded    <= 1'b0;
      gamePlaying  <= 1'b0;
      restartPulse <= 1'b0;
    end else begin
      frame_cnt    <= frame_cnt_nxt;
      lives        <= lives_nxt;
      credits      <= credits_nxt;
      highScore    <= high_nxt;
      newHighScore <= new_hs_nxt;
      gameEnded    <= (state_nxt == ST_ENDED);
      gamePlaying  <= (state_nxt == ST_PLAY);
      restartPulse <= start_ok;
    end
  end

endmodule
